q15_div_seq: RTL

- Sequential Q15 divider: the inverse operation to the package's Q15 multiply.
- Computes quot = num / den on q15_t operands using a radix-2 restoring algorithm, one quotient bit per cycle.
- Valid/ready on both sides. Used by gate-parameter normalisation and amplitude renormalisation after measurement collapse.
- One operation in flight at a time.

---
 rtl/fixed_point_pkg.sv | 11 +
 rtl/q15_div_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: Q15 fixed-point types, constants and helpers shared by the arithmetic blocks.
package fixed_point_pkg;
    typedef logic signed [15:0] q15_t;
    localparam q15_t MINUS_ONE = 16'sh8000;
    localparam q15_t PLUS_MAX = 16'sh7FFF;
    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} q15_div_state_t;
    // 17 bits so that |0x8000| = 32768 stays representable.
    function automatic logic [16:0] abs17_q15(input q15_t x);
        return x[15] ? -{x[15], x} : {1'b0, x};
    endfunction
endpackage

// File: rtl/q15_div_seq.sv
// q15_div_seq: sequential Q15 divider, radix-2 restoring, one quotient bit per cycle.
// Q15_DIV_ROUND_EN adds a guard iteration and rounds the magnitude half away from zero.
module q15_div_seq
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_num,
    input  logic [WIDTH-1:0] in_den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic             out_sat,
    output logic             out_div0,
    output logic             busy
);
`ifdef Q15_DIV_ROUND_EN
    localparam int ITERS = FRAC + 1;
`else
    localparam int ITERS = FRAC;
`endif
    localparam int CW = $clog2(ITERS + 1);
    q15_div_state_t r_state, w_next;
    logic             r_sign;
    logic [WIDTH:0]   r_num_mag, r_den_mag, r_rem, w_rem;
    logic [WIDTH+1:0] w_shift;
    logic             w_ge;
    logic [ITERS-2:0] r_q;
    logic [ITERS-1:0] w_q_nxt;
    logic [FRAC:0]    w_mag;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quot, w_quot;
    logic             r_sat, r_div0, w_sat, w_div0;
    // Remainder starts at |num|: the dividend |num|<<FRAC only feeds zeros from here on.
    assign w_shift = {r_rem, 1'b0};
    assign w_ge    = w_shift >= {1'b0, r_den_mag};
    assign w_rem   = (WIDTH+1)'(w_ge ? w_shift - {1'b0, r_den_mag} : w_shift);
    assign w_q_nxt = {r_q, w_ge};
`ifdef Q15_DIV_ROUND_EN
    assign w_mag = {1'b0, w_q_nxt[ITERS-1:1]} + (FRAC+1)'(w_q_nxt[0]);
`else
    assign w_mag = {1'b0, w_q_nxt};
`endif
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = DIV_CALC;
            end
            DIV_CALC: if (r_cnt == CW'(1)) w_next = DIV_DONE;
            DIV_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = DIV_IDLE;
            end
            default: w_next = DIV_IDLE;
        endcase
    end
    // A rounded magnitude of 0x8000 is only legal as -1.0; negation of it wraps there naturally.
    always_comb begin
        w_sat  = 1'b0;
        w_div0 = 1'b0;
        w_quot = r_sign ? -w_mag : w_mag;
        if (r_den_mag == '0) begin
            w_div0 = 1'b1;
            w_quot = r_num_mag == '0 ? '0 : r_sign ? MINUS_ONE : PLUS_MAX;
        end else if (r_num_mag == r_den_mag && r_sign) begin
            w_quot = MINUS_ONE;
        end else if (r_num_mag >= r_den_mag || (w_mag[FRAC] && !r_sign)) begin
            w_sat  = 1'b1;
            w_quot = r_sign ? MINUS_ONE : PLUS_MAX;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_IDLE;
            r_sign    <= 1'b0;
            r_num_mag <= '0;
            r_den_mag <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_sat     <= 1'b0;
            r_div0    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == DIV_IDLE && in_valid) begin
                r_sign    <= in_num[WIDTH-1] ^ in_den[WIDTH-1];
                r_num_mag <= abs17_q15(in_num);
                r_den_mag <= abs17_q15(in_den);
                r_rem     <= abs17_q15(in_num);
                r_q       <= '0;
                r_cnt     <= CW'(ITERS);
            end else if (r_state == DIV_CALC) begin
                r_rem <= w_rem;
                r_q   <= w_q_nxt[ITERS-2:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_quot <= w_quot;
                    r_sat  <= w_sat;
                    r_div0 <= w_div0;
                end
            end
        end
    end
    assign out_quot = r_quot;
    assign out_sat  = r_sat;
    assign out_div0 = r_div0;
    assign busy     = r_state != DIV_IDLE;
endmodule
